// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 constants and types for the memory stage.
//   - icode values, stat codes, the "no register" ID
//   - bubble field values for the W pipeline register
//   - memory-access decode type and helper
//   - W register record type
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Status codes
    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SHLT = 4'h2;
    localparam logic [3:0] SADR = 4'h3;
    localparam logic [3:0] SINS = 4'h4;

    // Register ID meaning "no destination"
    localparam logic [3:0] RNONE = 4'hF;

    // Bubble field values
    localparam logic [3:0]  BUBBLE_STAT  = SAOK;
    localparam logic [3:0]  BUBBLE_ICODE = INOP;
    localparam logic [3:0]  BUBBLE_DST   = RNONE;
    localparam logic [63:0] BUBBLE_VAL   = 64'h0;

    typedef enum logic [1:0] {
        AccNone,
        AccRead,
        AccWrite
    } mem_acc_e;

    // Decoded memory control for one M-stage instruction
    typedef struct packed {
        mem_acc_e acc;
        logic     addr_sel_a;  // address from valA instead of valE
        logic     data_sel_p;  // write data from valP instead of valA
    } mem_ctl_t;

    // W pipeline register contents
    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [63:0] val_e;
        logic [63:0] val_m;
    } w_reg_t;

    localparam w_reg_t W_BUBBLE = '{
        stat:  BUBBLE_STAT,
        icode: BUBBLE_ICODE,
        dst_e: BUBBLE_DST,
        dst_m: BUBBLE_DST,
        val_e: BUBBLE_VAL,
        val_m: BUBBLE_VAL
    };

    function automatic mem_ctl_t decode_mem(input logic [3:0] icode);
        mem_ctl_t ctl;
        ctl = '{acc: AccNone, addr_sel_a: 1'b0, data_sel_p: 1'b0};
        case (icode)
            IMRMOVQ:        ctl.acc = AccRead;
            IRET, IPOPQ: begin
                ctl.acc        = AccRead;
                ctl.addr_sel_a = 1'b1;
            end
            IRMMOVQ, IPUSHQ: ctl.acc = AccWrite;
            ICALL: begin
                ctl.acc        = AccWrite;
                ctl.data_sel_p = 1'b1;
            end
            default:        ctl.acc = AccNone;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 64-bit data storage, no reset.
//   clk    in   write clock
//   we     in   write enable, commits on rising clk
//   waddr  in   write word index
//   wdata  in   write data
//   raddr  in   read word index
//   rdata  out  combinational read data (old contents during a same-cycle write)
module dmem_array #(
    parameter int unsigned DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [63:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [63:0]              rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_memory_stage.sv
// data_memory_stage: Y86-64 M stage with data memory and the W pipeline register.
//   clk, rst                      clock, asynchronous active-high reset
//   m_stat, m_icode               M-stage status and instruction code
//   m_valE, m_valA, m_valP        ALU result, operand A, next PC
//   m_dstE, m_dstM                destination register IDs
//   w_stall, w_bubble             W register control (stall wins)
//   m_valM                        combinational read data (forwarding)
//   m_stat_o                      status after the address check
//   dmem_error                    address error for the current access
//   w_stat .. w_valM              W pipeline register outputs
module data_memory_stage
    import y86_pkg::*;
#(
    parameter int unsigned DEPTH       = 2048,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  m_stat,
    input  logic [3:0]  m_icode,
    input  logic [63:0] m_valE,
    input  logic [63:0] m_valA,
    input  logic [63:0] m_valP,
    input  logic [3:0]  m_dstE,
    input  logic [3:0]  m_dstM,
    input  logic        w_stall,
    input  logic        w_bubble,
    output logic [63:0] m_valM,
    output logic [3:0]  m_stat_o,
    output logic        dmem_error,
    output logic [3:0]  w_stat,
    output logic [3:0]  w_icode,
    output logic [3:0]  w_dstE,
    output logic [3:0]  w_dstM,
    output logic [63:0] w_valE,
    output logic [63:0] w_valM
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    mem_ctl_t          ctl;
    logic [63:0]       addr;
    logic [63:0]       wdata;
    logic [IDX_W-1:0]  idx;
    logic              out_of_range;
    logic              misaligned;
    logic              mem_we;
    logic [63:0]       rdata;
    logic              kill_q;
    w_reg_t            w_q;
    w_reg_t            w_d;

    // Access decode and address check
    always_comb begin
        ctl   = decode_mem(m_icode);
        addr  = ctl.addr_sel_a ? m_valA : m_valE;
        wdata = ctl.data_sel_p ? m_valP : m_valA;
        idx   = addr[IDX_W+2:3];
        // Any set bit above the word index puts the full 64-bit address past the end,
        // so there is no wrap-around of large addresses back into range.
        out_of_range = |addr[63:IDX_W+3];
        misaligned   = ALIGN_CHECK && (addr[2:0] != 3'b000);
        dmem_error   = (ctl.acc != AccNone) && (out_of_range || misaligned);
        m_stat_o     = dmem_error ? SADR : m_stat;
        m_valM       = ((ctl.acc == AccRead) && !dmem_error) ? rdata : 64'h0;
    end

    // kill_q is set by reset and cleared by the next clock edge, so a write that was in
    // flight when reset arrived is dropped even if reset is released before that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kill_q <= 1'b1;
        end else begin
            kill_q <= 1'b0;
        end
    end

    always_comb begin
        mem_we = (ctl.acc == AccWrite) && !dmem_error && (m_stat == SAOK) &&
                 (w_q.stat == SAOK) && !rst && !kill_q;
    end

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_dmem_array (
        .clk  (clk),
        .we   (mem_we),
        .waddr(idx),
        .wdata(wdata),
        .raddr(idx),
        .rdata(rdata)
    );

    // W register next state: stall holds, then bubble, then normal load
    always_comb begin
        w_d = w_q;
        if (w_stall) begin
            w_d = w_q;
        end else if (w_bubble) begin
            w_d = W_BUBBLE;
        end else begin
            w_d.stat  = m_stat_o;
            w_d.icode = m_icode;
            w_d.dst_e = m_dstE;
            w_d.dst_m = m_dstM;
            w_d.val_e = m_valE;
            w_d.val_m = m_valM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= W_BUBBLE;
        end else begin
            w_q <= w_d;
        end
    end

    assign w_stat  = w_q.stat;
    assign w_icode = w_q.icode;
    assign w_dstE  = w_q.dst_e;
    assign w_dstM  = w_q.dst_m;
    assign w_valE  = w_q.val_e;
    assign w_valM  = w_q.val_m;

endmodule

// File: tb/tb_data_memory_stage.sv
module tb_data_memory_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  m_stat = 4'h1, m_icode = 4'h1, m_dstE = 4'hF, m_dstM = 4'hF;
    logic [63:0] m_valE = '0, m_valA = '0, m_valP = '0;
    logic        w_stall = 1'b0, w_bubble = 1'b0;

    // Aligned-check instance
    logic [63:0] a_valM, a_w_valE, a_w_valM;
    logic [3:0]  a_stat_o, a_w_stat, a_w_icode, a_w_dstE, a_w_dstM;
    logic        a_err;
    // Alignment check disabled
    logic [63:0] n_valM, n_w_valE, n_w_valM;
    logic [3:0]  n_stat_o, n_w_stat, n_w_icode, n_w_dstE, n_w_dstM;
    logic        n_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_stage #(.DEPTH(2048), .ALIGN_CHECK(1'b1)) u_dut (
        .clk(clk), .rst(rst), .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE),
        .m_valA(m_valA), .m_valP(m_valP), .m_dstE(m_dstE), .m_dstM(m_dstM),
        .w_stall(w_stall), .w_bubble(w_bubble), .m_valM(a_valM), .m_stat_o(a_stat_o),
        .dmem_error(a_err), .w_stat(a_w_stat), .w_icode(a_w_icode), .w_dstE(a_w_dstE),
        .w_dstM(a_w_dstM), .w_valE(a_w_valE), .w_valM(a_w_valM)
    );

    data_memory_stage #(.DEPTH(2048), .ALIGN_CHECK(1'b0)) u_dut_na (
        .clk(clk), .rst(rst), .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE),
        .m_valA(m_valA), .m_valP(m_valP), .m_dstE(m_dstE), .m_dstM(m_dstM),
        .w_stall(w_stall), .w_bubble(w_bubble), .m_valM(n_valM), .m_stat_o(n_stat_o),
        .dmem_error(n_err), .w_stat(n_w_stat), .w_icode(n_w_icode), .w_dstE(n_w_dstE),
        .w_dstM(n_w_dstM), .w_valE(n_w_valE), .w_valM(n_w_valM)
    );

    typedef struct {
        logic [3:0]  stat, icode;
        logic [63:0] val_e, val_a, val_p;
        logic [3:0]  dst_e, dst_m;
        logic        stall, bubble;
        logic [63:0] e_valm;
        logic [3:0]  e_stat;
        logic        e_err;
        logic [63:0] e_na_valm;
        logic        e_na_err;
        logic [3:0]  ew_stat, ew_icode, ew_dste, ew_dstm;
        logic [63:0] ew_vale, ew_valm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [3:0] stat, input logic [3:0] icode, input logic [63:0] val_e,
        input logic [63:0] val_a, input logic [63:0] val_p, input logic [3:0] dst_e,
        input logic [3:0] dst_m, input logic stall, input logic bubble,
        input logic [63:0] e_valm, input logic [3:0] e_stat, input logic e_err,
        input logic [63:0] e_na_valm, input logic e_na_err,
        input logic [3:0] ew_stat, input logic [3:0] ew_icode, input logic [3:0] ew_dste,
        input logic [3:0] ew_dstm, input logic [63:0] ew_vale, input logic [63:0] ew_valm);
        vec_t v;
        v.stat = stat; v.icode = icode; v.val_e = val_e; v.val_a = val_a; v.val_p = val_p;
        v.dst_e = dst_e; v.dst_m = dst_m; v.stall = stall; v.bubble = bubble;
        v.e_valm = e_valm; v.e_stat = e_stat; v.e_err = e_err;
        v.e_na_valm = e_na_valm; v.e_na_err = e_na_err;
        v.ew_stat = ew_stat; v.ew_icode = ew_icode; v.ew_dste = ew_dste; v.ew_dstm = ew_dstm;
        v.ew_vale = ew_vale; v.ew_valm = ew_valm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_w_bubble(input string tag);
        chk({tag, " w_stat"}, a_w_stat, 4'h1);
        chk({tag, " w_icode"}, a_w_icode, 4'h1);
        chk({tag, " w_dstE"}, a_w_dstE, 4'hF);
        chk({tag, " w_dstM"}, a_w_dstM, 4'hF);
        chk({tag, " w_valE"}, a_w_valE, 64'h0);
        chk({tag, " w_valM"}, a_w_valM, 64'h0);
    endtask

    initial begin
        //         stat icode valE        valA     valP  dE   dM   st b   valM    st  er naM     ne
        //         wst wic wdE  wdM  wvalE       wvalM
        vecs.push_back(mk(1, 1, 64'h0,   64'h0,    0, 4'hF, 4'hF, 0, 0, 0, 1, 0, 0, 0,
                          1, 1, 4'hF, 4'hF, 64'h0, 0));
        vecs.push_back(mk(1, 4, 64'h100, 64'hDEAD, 0, 4'hF, 4'hF, 0, 0, 0, 1, 0, 0, 0,
                          1, 4, 4'hF, 4'hF, 64'h100, 0));
        vecs.push_back(mk(1, 5, 64'h100, 64'h0,    0, 4'hF, 4'h3, 0, 0, 64'hDEAD, 1, 0,
                          64'hDEAD, 0, 1, 5, 4'hF, 4'h3, 64'h100, 64'hDEAD));
        vecs.push_back(mk(1, 8, 64'h7F8, 64'h0, 64'h40, 4'h4, 4'hF, 0, 0, 0, 1, 0, 0, 0,
                          1, 8, 4'h4, 4'hF, 64'h7F8, 0));
        vecs.push_back(mk(1, 9, 64'h800, 64'h7F8,  0, 4'h4, 4'hF, 0, 0, 64'h40, 1, 0,
                          64'h40, 0, 1, 9, 4'h4, 4'hF, 64'h800, 64'h40));
        vecs.push_back(mk(1, 4, 64'h0,   64'h1111, 0, 4'hF, 4'hF, 0, 0, 0, 1, 0, 0, 0,
                          1, 4, 4'hF, 4'hF, 64'h0, 0));
        // One word past the end: index bits alias word 0, which must stay 0x1111
        vecs.push_back(mk(1, 4, 64'h4000, 64'h2222, 0, 4'hF, 4'hF, 0, 0, 0, 3, 1, 0, 1,
                          3, 4, 4'hF, 4'hF, 64'h4000, 0));
        vecs.push_back(mk(1, 5, 64'h0,   64'h0,    0, 4'hF, 4'h5, 0, 0, 64'h1111, 1, 0,
                          64'h1111, 0, 1, 5, 4'hF, 4'h5, 64'h0, 64'h1111));
        vecs.push_back(mk(1, 10, 64'h200, 64'h5555, 0, 4'h4, 4'hF, 0, 0, 0, 1, 0, 0, 0,
                          1, 10, 4'h4, 4'hF, 64'h200, 0));
        vecs.push_back(mk(1, 11, 64'h208, 64'h200, 0, 4'h4, 4'h6, 0, 0, 64'h5555, 1, 0,
                          64'h5555, 0, 1, 11, 4'h4, 4'h6, 64'h208, 64'h5555));
        // Misaligned read: error with the check, word 0x100 without it
        vecs.push_back(mk(1, 5, 64'h104, 64'h0,    0, 4'hF, 4'h7, 0, 0, 0, 3, 1,
                          64'hDEAD, 0, 3, 5, 4'hF, 4'h7, 64'h104, 0));
        vecs.push_back(mk(1, 6, 64'h123, 64'h100,  0, 4'h2, 4'hF, 0, 0, 0, 1, 0, 0, 0,
                          1, 6, 4'h2, 4'hF, 64'h123, 0));
        vecs.push_back(mk(1, 5, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0, 4'hF, 4'h1, 0, 0, 0, 3, 1,
                          0, 1, 3, 5, 4'hF, 4'h1, 64'hFFFF_FFFF_FFFF_FFF8, 0));
        vecs.push_back(mk(1, 1, 64'h0,   64'h0,    0, 4'hF, 4'hF, 0, 0, 0, 1, 0, 0, 0,
                          1, 1, 4'hF, 4'hF, 64'h0, 0));
        // Write with m_stat=HLT: no commit
        vecs.push_back(mk(2, 4, 64'h100, 64'hBEEF, 0, 4'hF, 4'hF, 0, 0, 0, 2, 0, 0, 0,
                          2, 4, 4'hF, 4'hF, 64'h100, 0));
        // AOK write while W holds HLT: no commit
        vecs.push_back(mk(1, 4, 64'h100, 64'hCAFE, 0, 4'hF, 4'hF, 0, 0, 0, 1, 0, 0, 0,
                          1, 4, 4'hF, 4'hF, 64'h100, 0));
        vecs.push_back(mk(1, 5, 64'h100, 64'h0,    0, 4'hF, 4'h3, 0, 0, 64'hDEAD, 1, 0,
                          64'hDEAD, 0, 1, 5, 4'hF, 4'h3, 64'h100, 64'hDEAD));
        vecs.push_back(mk(1, 6, 64'h77,  64'h0,    0, 4'h4, 4'hF, 0, 0, 0, 1, 0, 0, 0,
                          1, 6, 4'h4, 4'hF, 64'h77, 0));
        // Stall and bubble together: W holds
        vecs.push_back(mk(1, 5, 64'h100, 64'h0,    0, 4'hF, 4'h3, 1, 1, 64'hDEAD, 1, 0,
                          64'hDEAD, 0, 1, 6, 4'h4, 4'hF, 64'h77, 0));
        // Bubble alone
        vecs.push_back(mk(1, 5, 64'h100, 64'h0,    0, 4'hF, 4'h3, 0, 1, 64'hDEAD, 1, 0,
                          64'hDEAD, 0, 1, 1, 4'hF, 4'hF, 64'h0, 0));
        vecs.push_back(mk(1, 4, 64'h400, 64'hAAAA, 0, 4'hF, 4'hF, 0, 0, 0, 1, 0, 0, 0,
                          1, 4, 4'hF, 4'hF, 64'h400, 0));

        // Asynchronous reset loads a bubble without a clock edge
        #2 rst = 1'b1;
        #1 chk_w_bubble("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            m_stat = vecs[i].stat; m_icode = vecs[i].icode; m_valE = vecs[i].val_e;
            m_valA = vecs[i].val_a; m_valP = vecs[i].val_p; m_dstE = vecs[i].dst_e;
            m_dstM = vecs[i].dst_m; w_stall = vecs[i].stall; w_bubble = vecs[i].bubble;
            #1;
            chk($sformatf("v%0d m_valM", i), a_valM, vecs[i].e_valm);
            chk($sformatf("v%0d m_stat_o", i), a_stat_o, vecs[i].e_stat);
            chk($sformatf("v%0d dmem_error", i), a_err, vecs[i].e_err);
            chk($sformatf("v%0d na m_valM", i), n_valM, vecs[i].e_na_valm);
            chk($sformatf("v%0d na dmem_error", i), n_err, vecs[i].e_na_err);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d w_stat", i), a_w_stat, vecs[i].ew_stat);
            chk($sformatf("v%0d w_icode", i), a_w_icode, vecs[i].ew_icode);
            chk($sformatf("v%0d w_dstE", i), a_w_dstE, vecs[i].ew_dste);
            chk($sformatf("v%0d w_dstM", i), a_w_dstM, vecs[i].ew_dstm);
            chk($sformatf("v%0d w_valE", i), a_w_valE, vecs[i].ew_vale);
            chk($sformatf("v%0d w_valM", i), a_w_valM, vecs[i].ew_valm);
        end
        w_stall = 1'b0; w_bubble = 1'b0;

        // Reset pulse between edges during a pushq to 0x400 (holding 0xAAAA)
        @(negedge clk);
        m_stat = 4'h1; m_icode = 4'hA; m_valE = 64'h400; m_valA = 64'hBBBB;
        m_valP = 64'h0; m_dstE = 4'h4; m_dstM = 4'hF;
        #1 chk("pre-rst w_icode", a_w_icode, 4'h4);
        #1 rst = 1'b1;
        #1 chk_w_bubble("mid-rst");
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst w_icode", a_w_icode, 4'hA);
        chk("post-rst w_valE", a_w_valE, 64'h400);
        @(negedge clk);
        m_icode = 4'h5; m_valE = 64'h400; m_valA = 64'h0; m_dstE = 4'hF; m_dstM = 4'h2;
        #1;
        chk("rst-discard m_valM", a_valM, 64'hAAAA);
        chk("rst-discard na m_valM", n_valM, 64'hAAAA);
        @(posedge clk);
        #1 chk("rst-discard w_valM", a_w_valM, 64'hAAAA);

        // Same-cycle write returns old data; new data appears next cycle
        @(negedge clk);
        m_icode = 4'h4; m_valE = 64'h400; m_valA = 64'h1234; m_dstM = 4'hF;
        @(negedge clk);
        m_icode = 4'h5; m_dstM = 4'h2;
        #1 chk("rw m_valM", a_valM, 64'h1234);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_stage.md
DATA_MEMORY_STAGE -- requirements
Module: data_memory_stage

Interface
REQ-001 Parameter DEPTH, default 2048, number of 64-bit words in data memory (power of two, 16..65536).
REQ-002 Parameter ALIGN_CHECK, default 1, enables the misaligned-address error when 1.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 m_stat  in  4  stat of the M-stage instruction (1 AOK, 2 HLT, 3 ADR, 4 INS).
REQ-006 m_icode  in  4  M-stage icode.
REQ-007 m_valE, m_valA, m_valP  in  64 each  ALU result, operand A, next PC.
REQ-008 m_dstE, m_dstM  in  4 each  destination register IDs (0xF = none).
REQ-009 w_stall  in  1  hold the W register.
REQ-010 w_bubble  in  1  load a bubble into the W register.
REQ-011 m_valM  out  64  combinational read data, used for forwarding.
REQ-012 m_stat_o  out  4  combinational stat after the memory check.
REQ-013 dmem_error  out  1  combinational address error for the current access.
REQ-014 w_stat, w_icode, w_dstE, w_dstM, w_valE, w_valM  out  4/4/4/4/64/64  W pipeline register.

Function
REQ-015 Read access SHALL occur for icode 5 (mrmovq) at address m_valE, and for icode 9 (ret) or 11 (popq) at address m_valA.
REQ-016 Write access SHALL occur for icode 4 (rmmovq) or 10 (pushq) with data m_valA at address m_valE, and for icode 8 (call) with data m_valP at address m_valE.
REQ-017 All other icodes SHALL perform no access, hold dmem_error=0 and drive m_valM=0.
REQ-018 Addresses are byte addresses; word index SHALL be addr[63:3].
REQ-019 dmem_error SHALL be 1 when an access has addr >= DEPTH*8, or when ALIGN_CHECK=1 and addr[2:0] != 0.
REQ-020 m_stat_o SHALL be 3 (ADR) when dmem_error=1, otherwise m_stat.
REQ-021 m_valM SHALL be the addressed word, read combinationally; it SHALL be 0 on error or when there is no read.
REQ-022 A write SHALL commit at the rising clk edge only when all of these hold: it is a write access, dmem_error=0, m_stat=AOK, and w_stat=AOK.
REQ-023 A faulting write, or any write while W holds a non-AOK stat, SHALL leave memory unchanged.
REQ-024 A read of an address in the same cycle as a write to it SHALL return the old contents; the next cycle SHALL return the new contents.
REQ-025 The W register SHALL, on a rising edge:
  - w_stall=1: hold its value;
  - else w_bubble=1: load a bubble;
  - else: load {m_stat_o, m_icode, m_dstE, m_dstM, m_valE, m_valM}.
REQ-026 w_stall SHALL take priority over w_bubble when both are asserted.
REQ-027 A bubble SHALL be: stat=1, icode=1 (nop), dstE=dstM=0xF, valE=valM=0.
REQ-028 Read latency SHALL be 0 cycles to m_valM and 1 cycle to w_valM.
REQ-029 Address arithmetic SHALL use the full 64 bits with no wrap-around; the value 0xFFFF_FFFF_FFFF_FFF8 SHALL be out of range.

Reset
REQ-030 Asserting rst SHALL immediately load a bubble into the W register, asynchronously.
REQ-031 Memory contents SHALL NOT be reset; no write SHALL commit while rst=1.
REQ-032 A reset asserted mid-access SHALL discard any pending write of that cycle.

Structure
REQ-033 Package y86_pkg SHALL hold the icode constants, stat codes (SAOK, SHLT, SADR, SINS), RNONE=0xF and the bubble field values.
REQ-034 Sub-module dmem_array SHALL hold the storage: parameter DEPTH, one combinational read port, one synchronous write port.
REQ-035 The address check and the W register SHALL be implemented in data_memory_stage.

Verification
REQ-036 rmmovq with valE=0x100 and valA=0xDEAD, then mrmovq with valE=0x100 -> m_valM=0xDEAD, and w_valM=0xDEAD one cycle later.
REQ-037 call with valE=0x7F8 and valP=0x40, then ret with valA=0x7F8 -> m_valM=0x40, dmem_error=0.
REQ-038 rmmovq with valE=DEPTH*8 -> dmem_error=1, m_stat_o=3, memory unchanged (verified by reading back the prior address), w_stat=3 after the edge.
REQ-039 With ALIGN_CHECK=1, mrmovq with valE=0x104 -> dmem_error=1, m_valM=0; with ALIGN_CHECK=0 the same access returns the word at 0x100.
REQ-040 w_stall=1 and w_bubble=1 together -> W holds its value; w_bubble alone -> w_icode=1, w_dstE=0xF.
REQ-041 rst pulsed between clock edges during a pushq -> W becomes a bubble immediately, and the target word retains its old value.
